// File: rtl/i2c_slave_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_slave_responder_if                                           |
// | Brief   : Bus-side and write-notification signals of the I2C target.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface i2c_slave_responder_if #(
    parameter int REG_DEPTH = 16
);
    localparam int c_ptr_w = $clog2(REG_DEPTH);

    logic               scl_i;
    logic               sda_i;
    logic               sda_oe;
    logic               wr_valid;
    logic [c_ptr_w-1:0] wr_addr;
    logic [7:0]         wr_data;
    logic               start_det;
    logic               stop_det;
    logic               busy;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe, wr_valid, wr_addr, wr_data, start_det, stop_det, busy
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe, wr_valid, wr_addr, wr_data, start_det, stop_det, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_slave_responder                                              |
// | Brief   : Oversampled I2C target with register file; optional SCL/SDA      |
// |           majority filter via I2C_SLAVE_GLITCH_FILTER_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_slave_responder #(
    parameter logic [6:0] OWN_ADDR    = 7'h68,
    parameter int         DATA_LENGTH = 8,
    parameter int         REG_DEPTH   = 16
) (
    input  wire logic             pclk,
    input  wire logic             areset,
    i2c_slave_responder_if.slave  bus
);
    localparam int c_ptr_w = $clog2(REG_DEPTH);

    generate
        if (DATA_LENGTH != 8 || REG_DEPTH < 2 || REG_DEPTH > 256 ||
            (REG_DEPTH & (REG_DEPTH - 1)) != 0) begin : g_param_check
            $error("i2c_slave_responder: DATA_LENGTH must be 8, REG_DEPTH a power of 2 in 2..256");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic               r_scl_d, r_sda_d;
    logic               w_scl, w_sda;
    logic [3:0]         r_cnt;
    logic [7:0]         r_shift;
    logic [c_ptr_w-1:0] r_ptr;
    logic               r_mack;
    logic               r_sda_oe, w_oe_nxt;
    logic               r_wr_valid, r_start_det, r_stop_det, r_busy;
    logic [c_ptr_w-1:0] r_wr_addr;
    logic [7:0]         r_wr_data;
    logic [7:0]         r_mem [REG_DEPTH];
    logic               w_wr_en, w_ptr_load, w_ptr_inc, w_cnt_clr;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= bus.sda_i;
            r_sda_s2 <= r_sda_s1;
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // Majority of three samples: a pulse one pclk wide never wins the vote.
    logic [2:0] r_scl_h, r_sda_h;
    logic       r_scl_f, r_sda_f;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_scl_h <= 3'b111;
            r_sda_h <= 3'b111;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[1:0], r_scl_s2};
            r_sda_h <= {r_sda_h[1:0], r_sda_s2};
            r_scl_f <= (r_scl_h[0] & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[2]) | (r_scl_h[1] & r_scl_h[2]);
            r_sda_f <= (r_sda_h[0] & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[2]) | (r_sda_h[1] & r_sda_h[2]);
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit, w_byte_state;
    logic [7:0] w_rd_byte;

    assign w_scl_rise   = w_scl & ~r_scl_d;
    assign w_scl_fall   = ~w_scl & r_scl_d;
    assign w_start      = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop       = ~r_sda_d & w_sda & w_scl & r_scl_d;
    // General call and the 10-bit prefix are never claimed, whatever OWN_ADDR is.
    assign w_addr_hit   = (r_shift[7:1] == OWN_ADDR) && (r_shift[7:1] != 7'h00) &&
                          (r_shift[7:3] != 5'b11110);
    assign w_byte_state = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WR_DATA);
    assign w_rd_byte    = r_mem[r_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_oe_nxt    = r_sda_oe;
        w_wr_en     = 1'b0;
        w_ptr_load  = 1'b0;
        w_ptr_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_cnt_clr   = 1'b1;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_oe_nxt    = 1'b0;
            w_cnt_clr   = 1'b1;
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR: if (r_cnt == 4'd8) begin
                    w_cnt_clr = 1'b1;
                    if (w_addr_hit) begin
                        w_state_nxt = S_ADDR_ACK;
                        w_oe_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_STOP;
                    end
                end
                S_ADDR_ACK: begin
                    w_cnt_clr = 1'b1;
                    if (r_shift[0]) begin
                        w_state_nxt = S_RD_DATA;
                        w_oe_nxt    = ~w_rd_byte[7];
                    end else begin
                        w_state_nxt = S_PTR;
                        w_oe_nxt    = 1'b0;
                    end
                end
                S_PTR: if (r_cnt == 4'd8) begin
                    w_cnt_clr   = 1'b1;
                    w_ptr_load  = 1'b1;
                    w_state_nxt = S_PTR_ACK;
                    w_oe_nxt    = 1'b1;
                end
                S_WR_DATA: if (r_cnt == 4'd8) begin
                    w_cnt_clr   = 1'b1;
                    w_wr_en     = 1'b1;
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = S_WR_ACK;
                    w_oe_nxt    = 1'b1;
                end
                S_PTR_ACK, S_WR_ACK: begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_WR_DATA;
                    w_oe_nxt    = 1'b0;
                end
                // r_cnt counts bits already presented; the next one is 6-r_cnt.
                S_RD_DATA: if (r_cnt == 4'd7) begin
                    w_cnt_clr   = 1'b1;
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = S_RD_ACK;
                    w_oe_nxt    = 1'b0;
                end else begin
                    w_oe_nxt = ~w_rd_byte[3'd6 - r_cnt[2:0]];
                end
                S_RD_ACK: begin
                    w_cnt_clr = 1'b1;
                    if (!r_mack) begin
                        w_state_nxt = S_RD_DATA;
                        w_oe_nxt    = ~w_rd_byte[7];
                    end else begin
                        w_state_nxt = S_WAIT_STOP;
                        w_oe_nxt    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state     <= S_IDLE;
            r_sda_oe    <= 1'b0;
            r_cnt       <= 4'd0;
            r_shift     <= 8'h00;
            r_ptr       <= '0;
            r_mack      <= 1'b1;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_sda_oe    <= w_oe_nxt;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
            r_wr_valid  <= w_wr_en;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            if (w_cnt_clr) begin
                r_cnt <= 4'd0;
            end else if (w_scl_rise && w_byte_state && r_cnt != 4'd8) begin
                r_cnt   <= r_cnt + 4'd1;
                r_shift <= {r_shift[6:0], w_sda};
            end else if (w_scl_fall && r_state == S_RD_DATA) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_scl_rise && r_state == S_RD_ACK) r_mack <= w_sda;
            if (w_ptr_load)     r_ptr <= r_shift[c_ptr_w-1:0];
            else if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;
            if (w_wr_en) begin
                r_mem[r_ptr] <= r_shift;
                r_wr_addr    <= r_ptr;
                r_wr_data    <= r_shift;
            end
        end
    end

    assign bus.sda_oe    = r_sda_oe;
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.start_det = r_start_det;
    assign bus.stop_det  = r_stop_det;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_i2c_slave_responder                                           |
// | Brief   : Directed I2C master bench for i2c_slave_responder.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_i2c_slave_responder;
    logic pclk;
    logic areset;
    logic r_scl;
    logic r_sda_m;
    int   n_checks;
    int   n_pass;
    int   start_cnt;
    int   stop_cnt;
    bit   oe_seen;
    int   wr_q[$];

    i2c_slave_responder_if #(.REG_DEPTH(16)) bus ();

    i2c_slave_responder #(
        .OWN_ADDR    (7'h68),
        .DATA_LENGTH (8),
        .REG_DEPTH   (16)
    ) dut (
        .pclk   (pclk),
        .areset (areset),
        .bus    (bus)
    );

    // Open-drain bus: either side can pull SDA low.
    assign bus.scl_i = r_scl;
    assign bus.sda_i = r_sda_m & ~bus.sda_oe;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (bus.wr_valid)  wr_q.push_back((int'(bus.wr_addr) << 8) | int'(bus.wr_data));
        if (bus.start_det) start_cnt++;
        if (bus.stop_det)  stop_cnt++;
        if (bus.sda_oe)    oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic q_wait();
        repeat (5) @(negedge pclk);
    endtask

    task automatic i2c_start();
        r_sda_m = 1'b1; q_wait();
        r_scl   = 1'b1; q_wait();
        r_sda_m = 1'b0; q_wait();
        r_scl   = 1'b0; q_wait();
    endtask

    task automatic i2c_stop();
        r_sda_m = 1'b0; q_wait();
        r_scl   = 1'b1; q_wait();
        r_sda_m = 1'b1; q_wait();
    endtask

    task automatic bit_io(input logic b, input bit glitch, output logic s);
        r_sda_m = b; q_wait();
        r_scl = 1'b1;
        if (glitch) begin
            repeat (2) @(negedge pclk);
            r_scl = 1'b0;
            @(negedge pclk);
            r_scl = 1'b1;
            repeat (2) @(negedge pclk);
        end else begin
            q_wait();
        end
        s = bus.sda_i;
        q_wait();
        r_scl = 1'b0; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], 1'b0, s);
        bit_io(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        bit_io(mack, 1'b0, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] glitch_byte;
        int         n;
        int         base;
        int         got;
        n_checks = 0; n_pass = 0; start_cnt = 0; stop_cnt = 0; oe_seen = 1'b0;
        r_scl = 1'b1; r_sda_m = 1'b1; areset = 1'b0;
        repeat (5) @(negedge pclk);
        areset = 1'b1;
        repeat (5) @(negedge pclk);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_valid", bus.wr_valid, 0);

        // Plain write of two bytes from pointer 3
        base = stop_cnt;
        i2c_start();
        check("t1_busy_set", bus.busy, 1);
        write_byte(8'hD0, ack); check("t1_addr_ack", ack, 0);
        write_byte(8'h03, ack); check("t1_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); check("t1_d0_ack", ack, 0);
        write_byte(8'h5A, ack); check("t1_d1_ack", ack, 0);
        i2c_stop(); q_wait();
        check("t1_wr_count", wr_q.size(), 2);
        check("t1_wr0", wr_q[0], 32'h3A5);
        check("t1_wr1", wr_q[1], 32'h45A);
        check("t1_stop_det", stop_cnt - base, 1);
        check("t1_busy_clr", bus.busy, 0);

        // Pointer write, repeated START, read two bytes
        base = start_cnt;
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hD1, ack); check("t2_rd_addr_ack", ack, 0);
        read_byte(1'b0, d); check("t2_rd0", d, 8'hA5);
        read_byte(1'b1, d); check("t2_rd1", d, 8'h5A);
        repeat (3) @(negedge pclk);
        check("t2_oe_after_nack", bus.sda_oe, 0);
        i2c_stop(); q_wait();
        check("t2_start_count", start_cnt - base, 2);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b1, d); check("t2_ptr5_read", d, 8'h00);
        i2c_stop(); q_wait();

        // Foreign address must be ignored completely
        n = wr_q.size(); oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack); check("t3_addr_nack", ack, 1);
        write_byte(8'h00, ack);
        i2c_stop(); q_wait();
        check("t3_oe_never", oe_seen, 0);
        check("t3_no_write", wr_q.size(), n);

        // Pointer wrap on write and on read
        n = wr_q.size();
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        i2c_stop(); q_wait();
        check("t4_wr_count", wr_q.size() - n, 2);
        got = (wr_q.size() > n) ? wr_q[n] : -1;
        check("t4_wr_15", got, 32'hF11);
        got = (wr_q.size() > n + 1) ? wr_q[n+1] : -1;
        check("t4_wr_0", got, 32'h022);
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h0F, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b0, d); check("t4_rd_15", d, 8'h11);
        read_byte(1'b1, d); check("t4_rd_0", d, 8'h22);
        i2c_stop(); q_wait();

        // STOP in the middle of a data byte
        n = wr_q.size();
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h02, ack);
        for (int i = 0; i < 4; i++) bit_io(1'b1, 1'b0, s);
        i2c_stop(); q_wait();
        check("t5_abort_no_wr", wr_q.size(), n);
        check("t5_abort_busy", bus.busy, 0);
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h02, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b1, d); check("t5_mem2_kept", d, 8'h00);
        i2c_stop(); q_wait();

        // Reset while the target drives its address ACK
        i2c_start();
        d = 8'hD1;
        for (int i = 7; i >= 0; i--) bit_io(d[i], 1'b0, s);
        r_sda_m = 1'b1; q_wait();
        r_scl = 1'b1;
        repeat (2) @(negedge pclk);
        check("t5_ack_driven", bus.sda_oe, 1);
        #2 areset = 1'b0;
        #1 check("t5_async_release", bus.sda_oe, 0);
        repeat (3) @(negedge pclk);
        areset = 1'b1;
        r_sda_m = 1'b1;
        repeat (5) @(negedge pclk);
        check("t5_busy_after_rst", bus.busy, 0);
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b1, d); check("t5_mem_cleared", d, 8'h00);
        i2c_stop(); q_wait();

        // One-pclk SCL low glitch during the 4th bit of 0xC3
        n = wr_q.size();
        glitch_byte = 8'hC3;
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h06, ack);
        for (int i = 7; i >= 0; i--) bit_io(glitch_byte[i], (i == 4), s);
        bit_io(1'b1, 1'b0, s);
        i2c_stop(); q_wait();
        check("t6_wr_count", wr_q.size() - n, 1);
        got = (wr_q.size() > n) ? wr_q[n] : -1;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("t6_glitch_filtered", got, 32'h6C3);
`else
        check("t6_glitch_extra_bit", got, 32'h6C1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
